instr_sequencer: RTL

//  Multi-cycle control FSM for the non-pipelined MIPS core. Sequences each instruction through

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/instr_sequencer_op_class_decode.sv | 38 +++
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types for the multi-cycle MIPS control path: sequencer states,
// recognised opcodes and the per-opcode class bundle.
package mips_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        HALT
    } seq_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef struct packed {
        logic writes_reg;
        logic is_load;
        logic is_store;
        logic is_beq;
        logic is_bne;
        logic is_jump;
        logic is_link;
        logic is_halt;
        logic is_illegal;
    } op_class_t;

endpackage

// File: rtl/instr_sequencer_op_class_decode.sv
// Combinational opcode classifier feeding the sequencer's Moore decode.
// is_jump marks plain j only; jal is reported through is_link.
module op_class_decode
    import mips_pkg::*;
#(
    parameter logic [5:0] OPC_HALT = OP_HALT
) (
    input  logic [5:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        // The halt opcode is a parameter, so it is matched ahead of the fixed table.
        if (opcode == OPC_HALT) begin
            cls.is_halt = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE, OP_ADDI, OP_SLTI,
                OP_ANDI, OP_ORI, OP_LUI: cls.writes_reg = 1'b1;
                OP_LW: begin
                    cls.writes_reg = 1'b1;
                    cls.is_load    = 1'b1;
                end
                OP_SW:  cls.is_store = 1'b1;
                OP_BEQ: cls.is_beq   = 1'b1;
                OP_BNE: cls.is_bne   = 1'b1;
                OP_J:   cls.is_jump  = 1'b1;
                OP_JAL: begin
                    cls.writes_reg = 1'b1;
                    cls.is_link    = 1'b1;
                end
                default: cls.is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory timeout.
// Define SEQ_PERF_CNT_EN to add the instr_count/stall_count outputs.
module instr_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [5:0]  OPC_HALT    = 6'h3F
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [5:0]  opcode,
    input  logic        alu_zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_pause,
    output logic        pc_branch,
    output logic        pc_jump,
    output logic        halted,
    output logic        bus_err,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0] instr_count,
    output logic [31:0] stall_count,
`endif
    output logic        illegal_op
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    seq_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           bus_err_q, bus_err_d;
    logic           illegal_q, illegal_d;
    logic           fetch_req;
    op_class_t      cls;

    op_class_decode #(.OPC_HALT(OPC_HALT)) u_dec (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        fetch_req = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        pc_pause  = 1'b1;
        pc_branch = 1'b0;
        pc_jump   = 1'b0;
        case (state_q)
            FETCH: begin
                fetch_req = 1'b1;
                if (imem_ready) begin
                    state_d = DECODE;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DECODE: begin
                if (cls.is_halt) begin
                    state_d = HALT;
                end else if (cls.is_illegal) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (cls.is_load || cls.is_store) begin
                    state_d = MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls.is_store;
                // A ready arriving on the last allowed cycle still completes the access.
                if (dmem_ready) begin
                    state_d = WB;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WB: begin
                pc_pause  = 1'b0;
                reg_we    = cls.writes_reg;
                pc_branch = (cls.is_beq & alu_zero) | (cls.is_bne & ~alu_zero);
                pc_jump   = cls.is_jump | cls.is_link;
                state_d   = FETCH;
                cnt_d     = '0;
            end
            default: ;
        endcase
    end

    // Gated by nReset so no fetch is requested while reset is held.
    assign imem_req   = fetch_req & nReset;
    assign ir_load    = imem_req & imem_ready;
    assign halted     = (state_q == HALT);
    assign bus_err    = bus_err_q;
    assign illegal_op = illegal_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] instr_cnt_q, stall_cnt_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == WB)
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if ((state_q == FETCH && !imem_ready) || (state_q == MEM && !dmem_ready))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign instr_count = instr_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule
